// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX scheduler: FSM state and
// arbiter grant encodings plus the default fixed message.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ECHO_RD  = 3'd1,
        ECHO_CAP = 3'd2,
        ECHO_WR  = 3'd3,
        MSG_WR   = 3'd4
    } state_e;

    typedef enum logic {
        GNT_ECHO = 1'b0,
        GNT_MSG  = 1'b1
    } grant_e;

    localparam logic [31:0] MSG_DEFAULT = 32'h4F4B0D0A;

    // Byte 0 is the most significant byte of the message word.
    function automatic logic [7:0] msg_byte(input logic [31:0] msg, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = msg[31:24];
            2'd1:    b = msg[23:16];
            2'd2:    b = msg[15:8];
            default: b = msg[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: req[0] is the echo path, req[1] the
// message sender; a tie goes to whichever side was not granted last.
module rr_arb2
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    grant_e last_q, last_d;

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] & (~req[1] | (last_q == GNT_MSG));
        grant[1] = req[1] & ~grant[0];
    end

    always_comb begin
        last_d = last_q;
        if (advance && grant[0]) begin
            last_d = GNT_ECHO;
        end else if (advance && grant[1]) begin
            last_d = GNT_MSG;
        end
    end

    // Starting from MSG makes the first tie after reset go to the echo path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= GNT_MSG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Schedules TX FIFO writes between an RX-to-TX echo path and a fixed
// message sender, honouring RX empty and TX full at all times.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter logic [31:0] MSG     = MSG_DEFAULT,
    parameter int          MSG_LEN = 4,
    parameter int          CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_rdempty,
    input  logic [7:0]       rx_rdata,
    output logic             rx_rdreq,
    input  logic             tx_tfull,
    output logic [7:0]       tx_tdata,
    output logic             tx_twrreq,
    input  logic             echo_en,
    input  logic             msg_req,
    output logic             msg_busy,
    output logic [CNT_W-1:0] echo_cnt
);

    localparam logic [1:0] LAST_IDX = 2'(MSG_LEN - 1);

    state_e           state_q, state_d;
    logic             msg_pend_q, msg_pend_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       tdata_q, tdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] req;
    logic [1:0] grant;
    logic       advance;

    assign req     = {msg_pend_q, echo_en & ~rx_rdempty};
    assign advance = (state_q == IDLE) && (req != 2'b00);

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_d    = state_q;
        msg_pend_d = msg_pend_q;
        idx_d      = idx_q;
        tdata_d    = tdata_q;
        cnt_d      = cnt_q;

        // A request that arrives while one is pending or being sent is dropped.
        if (msg_req && (state_q != MSG_WR)) begin
            msg_pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (grant[0]) begin
                    state_d = ECHO_RD;
                end else if (grant[1]) begin
                    state_d    = MSG_WR;
                    msg_pend_d = 1'b0;
                    idx_d      = 2'd0;
                    tdata_d    = msg_byte(MSG, 2'd0);
                end
            end
            ECHO_RD: begin
                state_d = ECHO_CAP;
            end
            ECHO_CAP: begin
                tdata_d = rx_rdata;
                state_d = ECHO_WR;
            end
            ECHO_WR: begin
                if (!tx_tfull) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            MSG_WR: begin
                if (!tx_tfull) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        tdata_d = msg_byte(MSG, idx_q + 2'd1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            msg_pend_q <= 1'b0;
            idx_q      <= 2'd0;
            tdata_q    <= 8'h00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            msg_pend_q <= msg_pend_d;
            idx_q      <= idx_d;
            tdata_q    <= tdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign rx_rdreq  = (state_q == ECHO_RD);
    assign tx_twrreq = ((state_q == ECHO_WR) || (state_q == MSG_WR)) && !tx_tfull;
    assign tx_tdata  = tdata_q;
    assign msg_busy  = msg_pend_q || (state_q == MSG_WR);
    assign echo_cnt  = cnt_q;

endmodule
